ball_motion: RTL
================

// Module: ball_motion
// PURPOSE
//  Ball position and direction engine for the breakout game; consumes per-pixel h_collision/v_collision
//  pulses and win/lose from collision_logic; produces ball_x/ball_y back to it and to the pixel renderer.
//  Collision pulses are latched during the active frame; the ball moves once per frame at the vsync
//  rising edge. It also runs the serve/play/halt sequencing.
// PARAMETERS
//  H_MIN       10'd0    left wall x (inclusive)
//  H_MAX       10'd639  right wall x (inclusive)
//  V_MIN       10'd0    top wall y (inclusive)
//  V_MAX       10'd479  bottom clamp y (no bounce; ball is lost there)
//  SERVE_X     10'd320  serve x position
//  SERVE_Y     10'd400  serve y position
//  SPEED       4'd2     pixels moved per frame, each axis; legal 1..15
//  SERVE_FRAMES 6'd30   frames held in SERVE before MOVE; legal 1..63
//  RAMP_HITS   4'd8     v_collision count per speed step (SPEED_RAMP_EN only)
//  MAX_SPEED   4'd6     speed ceiling (SPEED_RAMP_EN only); must be >= SPEED
// PORTS
//  pxl_clk      in   1   pixel clock; only clock
//  reset_n      in   1   asynchronous active-low reset
//  vsync        in   1   high = blanking/update window, low = active frame
//  start        in   1   level; new serve (highest priority)
//  win          in   1   level from collision_logic
//  lose         in   1   level from collision_logic
//  h_collision  in   1   horizontal-face hit pulse, sampled any cycle vsync=0
//  v_collision  in   1   vertical-face hit pulse, sampled any cycle vsync=0
//  ball_x       out  10  ball centre x
//  ball_y       out  10  ball centre y
//  dir_x        out  1   1 = moving right (+x), 0 = left
//  dir_y        out  1   1 = moving up (-y), 0 = down
//  state        out  2   0 IDLE, 1 SERVE, 2 MOVE, 3 HALT
//  frame_tick   out  1   1-cycle pulse on each detected vsync rising edge
//  cur_speed    out  4   speed in use
// BEHAVIOUR
//  Reset: state=IDLE, ball_x=SERVE_X, ball_y=SERVE_Y, dir_x=1, dir_y=1, frame_tick=0, cur_speed=SPEED,
//   vsync_d=0, h_hit=v_hit=0, serve_cnt=0, hit_cnt=0.
//  Edge detect: vsync_d registers vsync; frame edge = vsync & ~vsync_d; frame_tick is registered,
//   high in the cycle after the edge is sampled. Position updates land in that same cycle.
//  Latching: in MOVE with vsync=0, h_collision sets h_hit and v_collision sets v_hit (sticky).
//   Pulses while vsync=1 or outside MOVE are ignored. Both flags clear on every frame update.
//  start=1, any state: ->SERVE next clock; position=serve; dir_x=1, dir_y=1; flags, serve_cnt, hit_cnt
//   clear; cur_speed=SPEED. start held = stays in SERVE with serve_cnt=0.
//  IDLE: wait for start. SERVE: position frozen; serve_cnt++ per frame edge; at SERVE_FRAMES ->MOVE.
//   win/lose ignored in IDLE/SERVE.
//  MOVE: win|lose=1 ->HALT next clock; position frozen from that clock, no further update even if a
//   frame edge coincides. Otherwise, on a frame edge:
//   1) dir_x ^= h_hit; dir_y ^= v_hit (both toggle if both set).
//   2) Step in 11-bit unsigned arithmetic using post-toggle direction, no 10-bit wrap:
//      x right: x+cur_speed >= H_MAX -> ball_x=H_MAX, dir_x=0; else add.
//      x left:  x <= H_MIN+cur_speed -> ball_x=H_MIN, dir_x=1; else subtract.
//      y up:    y <= V_MIN+cur_speed -> ball_y=V_MIN, dir_y=0; else subtract.
//      y down:  y+cur_speed >= V_MAX -> ball_y=V_MAX, dir_y stays 0 (clamp, no bounce).
//   Wall rule overrides the step-1 toggle when both occur in one frame.
//  HALT: frozen until start. IDLE/HALT/SERVE do not move the ball.
// CONFIGURATION
//  SPEED_RAMP_EN defined: each latched v_hit consumed in a MOVE update increments hit_cnt (4b).
//   When hit_cnt reaches RAMP_HITS: hit_cnt=0, cur_speed=min(cur_speed+1, MAX_SPEED). The new speed
//   applies from the next frame.
//  SPEED_RAMP_EN undefined: no hit_cnt; cur_speed tied to SPEED.
// TESTING
//  Reset mid-MOVE -> all outputs at reset values on the same edge; state=0, ball=(320,400).
//  start pulse, 30 vsync edges -> state 1->2 on 30th; next edge ball=(322,398).
//  v_collision pulse at vcount 100 in MOVE, dir_y=1 -> next frame dir_y=0, ball_y +2.
//  h_collision and v_collision in same frame -> both dirs flip; pulse during vsync=1 -> no flip.
//  ball_x=638, dir_x=1, SPEED=2 -> ball_x=639, dir_x=0; ball_y=1, dir_y=1 -> ball_y=0, dir_y=0.
//  lose=1 in MOVE -> state=3 next clock, ball frozen over 5 frames; start -> SERVE at (320,400).

Source files
------------

// File: rtl/ball_motion.sv
// Ball position/direction engine for breakout: latches collisions during the active frame,
// moves the ball once per vsync rising edge and sequences IDLE/SERVE/MOVE/HALT. Optional macro: SPEED_RAMP_EN.
module ball_motion #(
  parameter logic [9:0] H_MIN        = 10'd0,
  parameter logic [9:0] H_MAX        = 10'd639,
  parameter logic [9:0] V_MIN        = 10'd0,
  parameter logic [9:0] V_MAX        = 10'd479,
  parameter logic [9:0] SERVE_X      = 10'd320,
  parameter logic [9:0] SERVE_Y      = 10'd400,
  parameter logic [3:0] SPEED        = 4'd2,
`ifdef SPEED_RAMP_EN
  parameter logic [3:0] RAMP_HITS    = 4'd8,
  parameter logic [3:0] MAX_SPEED    = 4'd6,
`endif
  parameter logic [5:0] SERVE_FRAMES = 6'd30
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       start,
  input  logic       win,
  input  logic       lose,
  input  logic       h_collision,
  input  logic       v_collision,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [1:0] state,
  output logic       frame_tick,
  output logic [3:0] cur_speed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [5:0] SERVE_LAST = SERVE_FRAMES - 6'd1;

  state_t      r_state;
  logic [9:0]  r_ball_x, r_ball_y;
  logic        r_dir_x, r_dir_y;
  logic        r_vsync_d, r_frame_tick;
  logic        r_h_hit, r_v_hit;
  logic [5:0]  r_serve_cnt;

  logic        w_edge;
  logic        w_dir_x_t, w_dir_y_t;
  logic [3:0]  w_speed;
  logic [10:0] w_spd11, w_x11, w_y11;
  logic [9:0]  w_next_x, w_next_y;
  logic        w_next_dx, w_next_dy;

`ifdef SPEED_RAMP_EN
  logic [3:0]  r_hit_cnt;
  logic [3:0]  r_cur_speed;
  assign w_speed = r_cur_speed;
`else
  assign w_speed = SPEED;
`endif

  assign w_edge    = vsync & ~r_vsync_d;
  assign w_dir_x_t = r_dir_x ^ r_h_hit;
  assign w_dir_y_t = r_dir_y ^ r_v_hit;
  assign w_spd11   = {7'd0, w_speed};
  assign w_x11     = {1'b0, r_ball_x};
  assign w_y11     = {1'b0, r_ball_y};

  // 11-bit compares so a step past the wall clamps instead of wrapping.
  always_comb begin
    w_next_x  = r_ball_x;
    w_next_dx = w_dir_x_t;
    if (w_dir_x_t) begin
      if (w_x11 + w_spd11 >= {1'b0, H_MAX}) begin
        w_next_x  = H_MAX;
        w_next_dx = 1'b0;
      end else begin
        w_next_x = r_ball_x + {6'd0, w_speed};
      end
    end else begin
      if (w_x11 <= {1'b0, H_MIN} + w_spd11) begin
        w_next_x  = H_MIN;
        w_next_dx = 1'b1;
      end else begin
        w_next_x = r_ball_x - {6'd0, w_speed};
      end
    end
  end

  // Bottom is a clamp only: the ball is lost there, so direction stays downward.
  always_comb begin
    w_next_y  = r_ball_y;
    w_next_dy = w_dir_y_t;
    if (w_dir_y_t) begin
      if (w_y11 <= {1'b0, V_MIN} + w_spd11) begin
        w_next_y  = V_MIN;
        w_next_dy = 1'b0;
      end else begin
        w_next_y = r_ball_y - {6'd0, w_speed};
      end
    end else begin
      if (w_y11 + w_spd11 >= {1'b0, V_MAX}) begin
        w_next_y  = V_MAX;
        w_next_dy = 1'b0;
      end else begin
        w_next_y = r_ball_y + {6'd0, w_speed};
      end
    end
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ball_x     <= SERVE_X;
      r_ball_y     <= SERVE_Y;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_vsync_d    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_h_hit      <= 1'b0;
      r_v_hit      <= 1'b0;
      r_serve_cnt  <= 6'd0;
`ifdef SPEED_RAMP_EN
      r_hit_cnt    <= 4'd0;
      r_cur_speed  <= SPEED;
`endif
    end else begin
      r_vsync_d    <= vsync;
      r_frame_tick <= w_edge;
      if (start) begin
        r_state     <= ST_SERVE;
        r_ball_x    <= SERVE_X;
        r_ball_y    <= SERVE_Y;
        r_dir_x     <= 1'b1;
        r_dir_y     <= 1'b1;
        r_h_hit     <= 1'b0;
        r_v_hit     <= 1'b0;
        r_serve_cnt <= 6'd0;
`ifdef SPEED_RAMP_EN
        r_hit_cnt   <= 4'd0;
        r_cur_speed <= SPEED;
`endif
      end else begin
        case (r_state)
          ST_SERVE: begin
            if (w_edge) begin
              if (r_serve_cnt == SERVE_LAST) begin
                r_state     <= ST_MOVE;
                r_serve_cnt <= 6'd0;
              end else begin
                r_serve_cnt <= r_serve_cnt + 6'd1;
              end
            end
          end
          ST_MOVE: begin
            if (win | lose) begin
              r_state <= ST_HALT;
            end else if (w_edge) begin
              r_ball_x <= w_next_x;
              r_ball_y <= w_next_y;
              r_dir_x  <= w_next_dx;
              r_dir_y  <= w_next_dy;
              r_h_hit  <= 1'b0;
              r_v_hit  <= 1'b0;
`ifdef SPEED_RAMP_EN
              if (r_v_hit) begin
                if (r_hit_cnt + 4'd1 == RAMP_HITS) begin
                  r_hit_cnt <= 4'd0;
                  if (r_cur_speed < MAX_SPEED) r_cur_speed <= r_cur_speed + 4'd1;
                end else begin
                  r_hit_cnt <= r_hit_cnt + 4'd1;
                end
              end
`endif
            end else if (!vsync) begin
              if (h_collision) r_h_hit <= 1'b1;
              if (v_collision) r_v_hit <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign dir_x      = r_dir_x;
  assign dir_y      = r_dir_y;
  assign state      = r_state;
  assign frame_tick = r_frame_tick;
  assign cur_speed  = w_speed;

endmodule
